delay_slot_ctrl: RTL and testbench

//  Slot allocator and timer that sits directly upstream of the 7-slot delay register bank.
//  It drives that bank's write select (sel_reg) and read select (sel_mux).

---
 rtl/delay_pkg.sv | 26 ++
 rtl/slot_timer.sv | 33 +++
 rtl/delay_slot_ctrl.sv | 115 +++++++++++
 tb/tb_delay_slot_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared sizing constants and the slot priority encoder for the delay slot controller.
// Latency: n/a (package).
// Backpressure: n/a (package).
// Contents: select width A, bank size R, counter width CW, NSLOT usable slots,
//           SLOT_NONE code, lowest_slot() priority encoder.
package delay_pkg;

  localparam int A     = 3;
  localparam int R     = 1 << A;
  localparam int CW    = 4;
  localparam int NSLOT = R - 1;

  // Code 0 selects no slot; the bank reads constant zero.
  localparam logic [A-1:0] SLOT_NONE = '0;

  // Returns the 1-based code of the lowest set bit, or SLOT_NONE if no bit is set.
  function automatic logic [A-1:0] lowest_slot(input logic [NSLOT-1:0] v);
    logic [A-1:0] code;
    code = SLOT_NONE;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (v[i]) code = A'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-slot countdown timer: loads a count, decrements while running, flags zero.
// Latency: loaded value is visible the cycle after load; zero is combinational from the count.
// Backpressure: none; the count holds at zero until reloaded.
// Ports: clk, rst (async active-low), load/load_val (new count), run (slot occupied),
//        zero (count is zero).
module slot_timer
  import delay_pkg::*;
#(
  parameter int W = CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/delay_slot_ctrl.sv
// Slot allocator and timer driving the write/read selects of a 7-slot delay register bank.
// Latency: a sample written in cycle c is presented in cycle c+max(delay_cfg,1).
// Backpressure: in_ready drops when all slots are full; a presented slot holds until out_ready.
// Ports: clk, rst (async active-low); in_valid/in_ready/delay_cfg (upstream);
//        sel_reg/sel_mux (bank selects); out_valid/out_ready (downstream);
//        reg_mc (bank occupancy mirror), occ (internal occupancy), occ_err (sticky mismatch).
// Build option: define DELAY_OCC_CHECK_EN to compare occ against reg_mc every cycle.
module delay_slot_ctrl
  import delay_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    delay_cfg,
  output logic [A-1:0]     sel_reg,
  output logic [A-1:0]     sel_mux,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [NSLOT-1:0] reg_mc,
  output logic [NSLOT-1:0] occ,
  output logic             occ_err
);

  logic [NSLOT-1:0] occ_q;
  logic [NSLOT-1:0] occ_set;
  logic [NSLOT-1:0] occ_clr;
  logic [NSLOT-1:0] cnt_zero;
  logic [NSLOT-1:0] expired;
  logic [A-1:0]     alloc_slot;
  logic [A-1:0]     pick_slot;
  logic [A-1:0]     hold_slot_q;
  logic             hold_q;
  logic             accept;
  logic             transfer;
  logic [CW-1:0]    load_val;

  // Allocation looks only at registered occupancy, so a slot freed this cycle
  // is not handed out again until the next one.
  assign in_ready   = |(~occ_q);
  assign accept     = in_valid && in_ready;
  assign alloc_slot = lowest_slot(~occ_q);
  assign sel_reg    = accept ? alloc_slot : SLOT_NONE;

  // A zero delay behaves as one cycle; the timer counts down to zero.
  assign load_val = (delay_cfg == '0) ? '0 : delay_cfg - CW'(1);

  assign expired   = occ_q & cnt_zero;
  assign pick_slot = lowest_slot(expired);

  // Once a slot has been presented and stalled, it stays presented even if a
  // lower-index slot expires meanwhile; that one waits for the next turn.
  assign sel_mux   = hold_q ? hold_slot_q : pick_slot;
  assign out_valid = (sel_mux != SLOT_NONE);
  assign transfer  = out_valid && out_ready;

  always_comb begin
    occ_set = '0;
    occ_clr = '0;
    for (int k = 0; k < NSLOT; k++) begin
      occ_set[k] = accept && (alloc_slot == A'(k + 1));
      occ_clr[k] = transfer && (sel_mux == A'(k + 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q       <= '0;
      hold_q      <= 1'b0;
      hold_slot_q <= SLOT_NONE;
    end else begin
      occ_q <= (occ_q | occ_set) & ~occ_clr;
      if (out_valid && !out_ready) begin
        hold_q      <= 1'b1;
        hold_slot_q <= sel_mux;
      end else begin
        hold_q      <= 1'b0;
        hold_slot_q <= SLOT_NONE;
      end
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    slot_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (occ_set[g]),
      .load_val (load_val),
      .run      (occ_q[g]),
      .zero     (cnt_zero[g])
    );
  end

  assign occ = occ_q;

`ifdef DELAY_OCC_CHECK_EN
  logic occ_err_q;

  // Sticky: the first disagreement with the bank's own occupancy latches until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_err_q <= 1'b0;
    end else if (occ_q != reg_mc) begin
      occ_err_q <= 1'b1;
    end
  end

  assign occ_err = occ_err_q;
`else
  logic unused_reg_mc;
  assign unused_reg_mc = ^reg_mc;
  assign occ_err       = 1'b0;
`endif

endmodule

// File: tb/tb_delay_slot_ctrl.sv
// Directed self-checking bench for delay_slot_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_delay_slot_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] delay_cfg;
  logic [2:0] sel_reg;
  logic [2:0] sel_mux;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] reg_mc;
  logic [6:0] occ;
  logic       occ_err;

  logic       mc_force;
  logic [6:0] mc_val;

  int n_tests;
  int n_fail;

`ifdef DELAY_OCC_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  // The bank's occupancy mirror normally tracks occ; the checker test overrides it.
  assign reg_mc = mc_force ? mc_val : occ;

  delay_slot_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .delay_cfg (delay_cfg),
    .sel_reg   (sel_reg),
    .sel_mux   (sel_mux),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .reg_mc    (reg_mc),
    .occ       (occ),
    .occ_err   (occ_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_tests++; if (sel_reg !== 3'd0) begin n_fail++; $display("FAIL reset_sel_reg got=%0d exp=0", sel_reg); end
    n_tests++; if (sel_mux !== 3'd0) begin n_fail++; $display("FAIL reset_sel_mux got=%0d exp=0", sel_mux); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (occ !== 7'h00) begin n_fail++; $display("FAIL reset_occ got=%h exp=00", occ); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (occ_err !== 1'b0) begin n_fail++; $display("FAIL reset_occ_err got=%b exp=0", occ_err); end
  endtask

  task automatic test_single;
    in_valid = 1'b1; delay_cfg = 4'd3; out_ready = 1'b1;
    #1;
    n_tests++; if (sel_reg !== 3'd1) begin n_fail++; $display("FAIL single_sel_reg got=%0d exp=1", sel_reg); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    next_cycle;
    // Changing delay_cfg after the accept must not shorten the stored delay.
    in_valid = 1'b0; delay_cfg = 4'd1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_c1_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (occ !== 7'h01) begin n_fail++; $display("FAIL single_c1_occ got=%h exp=01", occ); end
    next_cycle; #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_c2_out_valid got=%b exp=0", out_valid); end
    next_cycle; #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_c3_out_valid got=%b exp=1", out_valid); end
    n_tests++; if (sel_mux !== 3'd1) begin n_fail++; $display("FAIL single_c3_sel_mux got=%0d exp=1", sel_mux); end
    next_cycle; #1;
    n_tests++; if (occ !== 7'h00) begin n_fail++; $display("FAIL single_c4_occ got=%h exp=00", occ); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_c4_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_zero_delay;
    for (int cfg = 0; cfg < 2; cfg++) begin
      in_valid = 1'b1; delay_cfg = 4'(cfg); out_ready = 1'b1;
      next_cycle;
      in_valid = 1'b0;
      #1;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_cfg%0d_out_valid got=%b exp=1", cfg, out_valid); end
      n_tests++; if (sel_mux !== 3'd1) begin n_fail++; $display("FAIL zero_cfg%0d_sel_mux got=%0d exp=1", cfg, sel_mux); end
      next_cycle; #1;
      n_tests++; if (occ !== 7'h00) begin n_fail++; $display("FAIL zero_cfg%0d_occ got=%h exp=00", cfg, occ); end
    end
  endtask

  task automatic test_fill_and_reset;
    out_ready = 1'b0; in_valid = 1'b1; delay_cfg = 4'd15;
    for (int i = 0; i < 7; i++) begin
      #1;
      n_tests++; if (sel_reg !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_sel_reg_%0d got=%0d exp=%0d", i, sel_reg, i + 1); end
      next_cycle;
    end
    #1;
    n_tests++; if (occ !== 7'h7F) begin n_fail++; $display("FAIL fill_occ got=%h exp=7f", occ); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    n_tests++; if (sel_reg !== 3'd0) begin n_fail++; $display("FAIL fill_sel_reg_full got=%0d exp=0", sel_reg); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_out_valid got=%b exp=0", out_valid); end
    next_cycle; #1;
    n_tests++; if (occ !== 7'h7F) begin n_fail++; $display("FAIL fill_hold_occ got=%h exp=7f", occ); end
    // Asynchronous reset mid-operation clears everything without a clock edge.
    rst = 1'b0;
    #1;
    n_tests++; if (occ !== 7'h00) begin n_fail++; $display("FAIL midrst_occ got=%h exp=00", occ); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (sel_mux !== 3'd0) begin n_fail++; $display("FAIL midrst_sel_mux got=%0d exp=0", sel_mux); end
    in_valid = 1'b0;
    next_cycle;
    rst = 1'b1;
    next_cycle;
  endtask

  task automatic test_collision;
    out_ready = 1'b1; in_valid = 1'b1; delay_cfg = 4'd5;
    next_cycle;
    delay_cfg = 4'd4;
    #1;
    n_tests++; if (sel_reg !== 3'd2) begin n_fail++; $display("FAIL coll_sel_reg got=%0d exp=2", sel_reg); end
    next_cycle;
    in_valid = 1'b0;
    next_cycle;
    next_cycle; #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL coll_c4_out_valid got=%b exp=0", out_valid); end
    next_cycle; #1;
    n_tests++; if ({out_valid, sel_mux} !== 4'b1001) begin n_fail++; $display("FAIL coll_c5 got=%b/%0d exp=1/1", out_valid, sel_mux); end
    next_cycle; #1;
    n_tests++; if ({out_valid, sel_mux} !== 4'b1010) begin n_fail++; $display("FAIL coll_c6 got=%b/%0d exp=1/2", out_valid, sel_mux); end
    next_cycle; #1;
    n_tests++; if (occ !== 7'h00) begin n_fail++; $display("FAIL coll_c7_occ got=%h exp=00", occ); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL coll_c7_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure;
    // Slot 2 expires first and stalls; slot 1 expires during the stall but must wait.
    out_ready = 1'b0; in_valid = 1'b1; delay_cfg = 4'd9;
    next_cycle;
    delay_cfg = 4'd1;
    #1;
    n_tests++; if (sel_reg !== 3'd2) begin n_fail++; $display("FAIL bp_sel_reg got=%0d exp=2", sel_reg); end
    next_cycle;
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1;
      n_tests++; if ({out_valid, sel_mux} !== 4'b1010) begin n_fail++; $display("FAIL bp_hold_%0d got=%b/%0d exp=1/2", i, out_valid, sel_mux); end
      next_cycle;
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (sel_mux !== 3'd2) begin n_fail++; $display("FAIL bp_xfer_sel_mux got=%0d exp=2", sel_mux); end
    next_cycle; #1;
    n_tests++; if ({out_valid, sel_mux} !== 4'b1001) begin n_fail++; $display("FAIL bp_next got=%b/%0d exp=1/1", out_valid, sel_mux); end
    n_tests++; if (occ !== 7'h01) begin n_fail++; $display("FAIL bp_occ_after got=%h exp=01", occ); end
    next_cycle; #1;
    n_tests++; if (occ !== 7'h00) begin n_fail++; $display("FAIL bp_occ_empty got=%h exp=00", occ); end
  endtask

  task automatic test_back_to_back;
    // Accept and transfer in the same cycle; the freed slot is not reused yet.
    out_ready = 1'b1; in_valid = 1'b1; delay_cfg = 4'd1;
    next_cycle;
    delay_cfg = 4'd3;
    #1;
    n_tests++; if ({out_valid, sel_mux} !== 4'b1001) begin n_fail++; $display("FAIL b2b_out got=%b/%0d exp=1/1", out_valid, sel_mux); end
    n_tests++; if (sel_reg !== 3'd2) begin n_fail++; $display("FAIL b2b_sel_reg got=%0d exp=2", sel_reg); end
    next_cycle;
    in_valid = 1'b0;
    #1;
    n_tests++; if (occ !== 7'h02) begin n_fail++; $display("FAIL b2b_occ got=%h exp=02", occ); end
    next_cycle;
    next_cycle; #1;
    n_tests++; if ({out_valid, sel_mux} !== 4'b1010) begin n_fail++; $display("FAIL b2b_expire got=%b/%0d exp=1/2", out_valid, sel_mux); end
    next_cycle; #1;
    n_tests++; if (occ !== 7'h00) begin n_fail++; $display("FAIL b2b_occ_empty got=%h exp=00", occ); end
  endtask

  task automatic test_occ_check;
    out_ready = 1'b0; in_valid = 1'b0;
    mc_val = 7'b0000100; mc_force = 1'b1;
    #1;
    n_tests++; if (occ_err !== 1'b0) begin n_fail++; $display("FAIL chk_before_edge got=%b exp=0", occ_err); end
    next_cycle;
    mc_force = 1'b0;
    #1;
    n_tests++; if (occ_err !== ERR_EXP) begin n_fail++; $display("FAIL chk_after_edge got=%b exp=%b", occ_err, ERR_EXP); end
    next_cycle;
    next_cycle; #1;
    n_tests++; if (occ_err !== ERR_EXP) begin n_fail++; $display("FAIL chk_sticky got=%b exp=%b", occ_err, ERR_EXP); end
    rst = 1'b0;
    #1;
    n_tests++; if (occ_err !== 1'b0) begin n_fail++; $display("FAIL chk_reset_clear got=%b exp=0", occ_err); end
    next_cycle;
    rst = 1'b1;
    next_cycle;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    delay_cfg = 4'd0;
    out_ready = 1'b0;
    mc_force  = 1'b0;
    mc_val    = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b1;
    next_cycle;
    test_single;
    test_zero_delay;
    test_fill_and_reset;
    test_collision;
    test_backpressure;
    test_back_to_back;
    test_occ_check;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
